// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control unit that drives every
// Datapath strobe from a Moore FSM (IDLE, T0..T6, HALTED).
//
// Ports:
//   clk        system clock, rising edge
//   clr        asynchronous active-low reset
//   run        level; 1 permits instruction fetch
//   mem_ready  memory data valid during T1
//   ir         IR contents from Datapath (opcode[31:27] Ra[26:23] Rb[22:19] Rc[18:15])
//   step       (SINGLE_STEP_EN only) advance out of STEP_WAIT
//   pc_out .. lo_in   single-bit Datapath strobes
//   r_in / r_out      one-hot register load / drive, NREG wide
//   op_code           ALU operation, nonzero only in the ALU cycle
//   busy / halted     status decoded from the state
//   illegal           sticky flag for an undefined opcode
//
// Optional feature: define SINGLE_STEP_EN to add the `step` input and the
// STEP_WAIT state entered at the end of every instruction.
//
// Outputs are decoded combinationally from the registered state (and ir), so
// an asynchronous reset forces them all to 0 in the same cycle.

module control_sequencer #(
    parameter int unsigned NREG = 16,
    parameter int unsigned OPW  = 5
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            run,
    input  logic            mem_ready,
    input  logic [31:0]     ir,
`ifdef SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic            pc_out,
    output logic            pc_increment,
    output logic            MARin,
    output logic            pc_in,
    output logic            read,
    output logic            mdr_in,
    output logic            mdr_out,
    output logic            ir_in,
    output logic            y_in,
    output logic            zhigh_in,
    output logic            zlow_in,
    output logic            zhigh_out,
    output logic            zlow_out,
    output logic            hi_in,
    output logic            lo_in,
    output logic [NREG-1:0] r_in,
    output logic [NREG-1:0] r_out,
    output logic [OPW-1:0]  op_code,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALTED
`ifdef SINGLE_STEP_EN
        , S_STEP_WAIT
`endif
    } state_t;

    typedef enum logic [2:0] {
        C_ALU3,
        C_MULDIV,
        C_UNARY,
        C_NOP,
        C_HALT,
        C_ILL
    } opclass_t;

    state_t   state_q;
    state_t   state_nxt;
    state_t   end_state;
    opclass_t cls;

    logic [4:0]      opc;
    logic [3:0]      ra;
    logic [3:0]      rb;
    logic [3:0]      rc;
    logic [NREG-1:0] sel_ra;
    logic [NREG-1:0] sel_rb;
    logic [NREG-1:0] sel_rc;
    logic            unused_ir_bits;

    assign opc            = ir[31:27];
    assign ra             = ir[26:23];
    assign rb             = ir[22:19];
    assign rc             = ir[18:15];
    assign unused_ir_bits = ^ir[14:0];

    // One-hot register select; an index beyond the register file selects nothing.
    function automatic logic [NREG-1:0] reg_sel(input logic [3:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        if (32'(idx) < NREG) v = NREG'(1) << idx;
        return v;
    endfunction

    assign sel_ra = reg_sel(ra);
    assign sel_rb = reg_sel(rb);
    assign sel_rc = reg_sel(rc);

    // Opcode class decode.
    always_comb begin
        cls = C_ILL;
        if (opc <= 5'd10) begin
            cls = C_ALU3;
        end else begin
            case (opc)
                5'd15, 5'd16: cls = C_MULDIV;
                5'd17, 5'd18: cls = C_UNARY;
                5'd26:        cls = C_NOP;
                5'd27:        cls = C_HALT;
                default:      cls = C_ILL;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= S_IDLE;
        else      state_q <= state_nxt;
    end

    // Sticky illegal-opcode flag, evaluated when the opcode is first decoded.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)                                  illegal <= 1'b0;
        else if (state_q == S_T3 && cls == C_ILL)  illegal <= 1'b1;
    end

`ifdef SINGLE_STEP_EN
    // Remembers that step has been low since (or just before) entering STEP_WAIT,
    // so a step held high across the end of an instruction is not taken as a pulse.
    logic step_armed;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)                        step_armed <= 1'b0;
        else if (state_q == S_STEP_WAIT) step_armed <= step_armed | ~step;
        else                             step_armed <= ~step;
    end
`endif

    assign busy   = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign halted = (state_q == S_HALTED);

    // Next-state and strobe decode.
    always_comb begin
        pc_out       = 1'b0;
        pc_increment = 1'b0;
        MARin        = 1'b0;
        pc_in        = 1'b0;
        read         = 1'b0;
        mdr_in       = 1'b0;
        mdr_out      = 1'b0;
        ir_in        = 1'b0;
        y_in         = 1'b0;
        zhigh_in     = 1'b0;
        zlow_in      = 1'b0;
        zhigh_out    = 1'b0;
        zlow_out     = 1'b0;
        hi_in        = 1'b0;
        lo_in        = 1'b0;
        r_in         = '0;
        r_out        = '0;
        op_code      = '0;
        state_nxt    = state_q;
`ifdef SINGLE_STEP_EN
        end_state    = S_STEP_WAIT;
`else
        end_state    = run ? S_T0 : S_IDLE;
`endif

        case (state_q)
            S_IDLE: begin
                if (run) state_nxt = S_T0;
            end
            S_T0: begin
                pc_out       = 1'b1;
                pc_increment = 1'b1;
                MARin        = 1'b1;
                zlow_in      = 1'b1;
                zhigh_in     = 1'b1;
                state_nxt    = S_T1;
            end
            S_T1: begin
                // Memory wait: strobes held, PC only loaded on the completing cycle.
                zlow_out = 1'b1;
                read     = 1'b1;
                mdr_in   = 1'b1;
                pc_in    = mem_ready;
                if (mem_ready) state_nxt = S_T2;
            end
            S_T2: begin
                mdr_out   = 1'b1;
                ir_in     = 1'b1;
                state_nxt = S_T3;
            end
            S_T3: begin
                case (cls)
                    C_ALU3: begin
                        r_out     = sel_rb;
                        y_in      = 1'b1;
                        state_nxt = S_T4;
                    end
                    C_MULDIV: begin
                        r_out     = sel_ra;
                        y_in      = 1'b1;
                        state_nxt = S_T4;
                    end
                    C_UNARY: begin
                        r_out     = sel_rb;
                        zlow_in   = 1'b1;
                        zhigh_in  = 1'b1;
                        op_code   = OPW'(opc);
                        state_nxt = S_T4;
                    end
                    C_HALT:  state_nxt = S_HALTED;
                    default: state_nxt = end_state;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_ALU3: begin
                        r_out     = sel_rc;
                        zlow_in   = 1'b1;
                        zhigh_in  = 1'b1;
                        op_code   = OPW'(opc);
                        state_nxt = S_T5;
                    end
                    C_MULDIV: begin
                        r_out     = sel_rb;
                        zlow_in   = 1'b1;
                        zhigh_in  = 1'b1;
                        op_code   = OPW'(opc);
                        state_nxt = S_T5;
                    end
                    C_UNARY: begin
                        zlow_out  = 1'b1;
                        r_in      = sel_ra;
                        state_nxt = end_state;
                    end
                    default: state_nxt = end_state;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_ALU3: begin
                        zlow_out  = 1'b1;
                        r_in      = sel_ra;
                        state_nxt = end_state;
                    end
                    C_MULDIV: begin
                        zlow_out  = 1'b1;
                        lo_in     = 1'b1;
                        state_nxt = S_T6;
                    end
                    default: state_nxt = end_state;
                endcase
            end
            S_T6: begin
                if (cls == C_MULDIV) begin
                    zhigh_out = 1'b1;
                    hi_in     = 1'b1;
                end
                state_nxt = end_state;
            end
            S_HALTED: begin
                state_nxt = S_HALTED;
            end
`ifdef SINGLE_STEP_EN
            S_STEP_WAIT: begin
                if (step && step_armed) state_nxt = run ? S_T0 : S_IDLE;
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the driver expands each instruction
// into its expected per-cycle strobe pattern (from the opcode-class tables) and
// queues it; a negedge monitor pops and compares against the DUT every cycle.

module tb_control_sequencer;

    localparam int unsigned NREG = 16;
    localparam int unsigned OPW  = 5;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        run = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] ir = '0;
`ifdef SINGLE_STEP_EN
    logic        step = 1'b0;
`endif

    logic            pc_out, pc_increment, mar_in, pc_in, read, mdr_in, mdr_out, ir_in, y_in;
    logic            zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in;
    logic [NREG-1:0] r_in, r_out;
    logic [OPW-1:0]  op_code;
    logic            busy, halted, illegal;

    control_sequencer #(.NREG(NREG), .OPW(OPW)) dut (
        .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .ir(ir),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .pc_out(pc_out), .pc_increment(pc_increment), .MARin(mar_in), .pc_in(pc_in),
        .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in),
        .zhigh_in(zhigh_in), .zlow_in(zlow_in), .zhigh_out(zhigh_out), .zlow_out(zlow_out),
        .hi_in(hi_in), .lo_in(lo_in), .r_in(r_in), .r_out(r_out), .op_code(op_code),
        .busy(busy), .halted(halted), .illegal(illegal)
    );

    typedef struct packed {
        logic        pc_out;
        logic        pc_increment;
        logic        mar_in;
        logic        pc_in;
        logic        read;
        logic        mdr_in;
        logic        mdr_out;
        logic        ir_in;
        logic        y_in;
        logic        zhigh_in;
        logic        zlow_in;
        logic        zhigh_out;
        logic        zlow_out;
        logic        hi_in;
        logic        lo_in;
        logic [15:0] r_in;
        logic [15:0] r_out;
        logic [4:0]  op_code;
        logic        busy;
        logic        halted;
        logic        illegal;
    } out_t;

    out_t act;
    out_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   ill     = 1'b0;
    bit   at_idle = 1'b1;

    always #5 clk = ~clk;

    always_comb act = {pc_out, pc_increment, mar_in, pc_in, read, mdr_in, mdr_out, ir_in, y_in,
                       zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in,
                       r_in, r_out, op_code, busy, halted, illegal};

    // Monitor: one expected word per cycle, compared mid-cycle.
    always @(negedge clk) begin
        out_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act, e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    // Apply one cycle of inputs and queue the outputs expected during that cycle.
    task automatic drive(input bit c, input bit r, input bit mr, input logic [31:0] irv, input out_t e);
        @(posedge clk);
        #1;
        clr       = c;
        run       = r;
        mem_ready = mr;
        ir        = irv;
`ifdef SINGLE_STEP_EN
        step      = 1'b0;
`endif
        e.illegal = ill;
        exp_q.push_back(e);
    endtask

`ifdef SINGLE_STEP_EN
    task automatic drive_s(input bit r, input bit mr, input logic [31:0] irv, input bit st, input out_t e);
        @(posedge clk);
        #1;
        run       = r;
        mem_ready = mr;
        ir        = irv;
        step      = st;
        e.illegal = ill;
        exp_q.push_back(e);
    endtask
`endif

    function automatic out_t act_e();
        out_t e;
        e      = '0;
        e.busy = 1'b1;
        return e;
    endfunction

    function automatic logic [15:0] bsel(input logic [3:0] i);
        return 16'(1) << i;
    endfunction

    // 0 ALU3, 1 MULDIV, 2 UNARY, 3 NOP, 4 HALT, 5 undefined
    function automatic int cls_of(input logic [4:0] opc);
        if (opc <= 5'd10)                  return 0;
        if (opc == 5'd15 || opc == 5'd16)  return 1;
        if (opc == 5'd17 || opc == 5'd18)  return 2;
        if (opc == 5'd26)                  return 3;
        if (opc == 5'd27)                  return 4;
        return 5;
    endfunction

    task automatic do_reset(input int n);
        ill = 1'b0;
        for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom), 1'($urandom), $urandom, out_t'('0));
        drive(1'b1, 1'b0, 1'($urandom), $urandom, out_t'('0));
        at_idle = 1'b1;
    endtask

    task automatic run_instr(input logic [31:0] instr, input int waits, input bit final_run, input bit abort_t4);
        out_t       e;
        out_t       ex[$];
        logic [4:0] opc;
        logic [3:0] ra, rb, rc;
        int         cls;
        int         last;
        bit         r;
        opc = instr[31:27];
        ra  = instr[26:23];
        rb  = instr[22:19];
        rc  = instr[18:15];
        cls = cls_of(opc);

        if (at_idle) begin
            repeat ($urandom_range(0, 2)) drive(1'b1, 1'b0, 1'($urandom), $urandom, out_t'('0));
            drive(1'b1, 1'b1, 1'($urandom), $urandom, out_t'('0));
            at_idle = 1'b0;
        end

        // Fetch; ir is garbage until T3.
        e = act_e(); e.pc_out = 1; e.pc_increment = 1; e.mar_in = 1; e.zlow_in = 1; e.zhigh_in = 1;
        drive(1'b1, 1'($urandom), 1'($urandom), $urandom, e);
        for (int w = 0; w < waits; w++) begin
            e = act_e(); e.zlow_out = 1; e.read = 1; e.mdr_in = 1;
            drive(1'b1, 1'($urandom), 1'b0, $urandom, e);
        end
        e = act_e(); e.zlow_out = 1; e.read = 1; e.mdr_in = 1; e.pc_in = 1;
        drive(1'b1, 1'($urandom), 1'b1, $urandom, e);
        e = act_e(); e.mdr_out = 1; e.ir_in = 1;
        drive(1'b1, 1'($urandom), 1'($urandom), $urandom, e);

        // Execute pattern per class.
        case (cls)
            0: begin
                e = act_e(); e.r_out = bsel(rb); e.y_in = 1; ex.push_back(e);
                e = act_e(); e.r_out = bsel(rc); e.zlow_in = 1; e.zhigh_in = 1; e.op_code = opc; ex.push_back(e);
                e = act_e(); e.zlow_out = 1; e.r_in = bsel(ra); ex.push_back(e);
            end
            1: begin
                e = act_e(); e.r_out = bsel(ra); e.y_in = 1; ex.push_back(e);
                e = act_e(); e.r_out = bsel(rb); e.zlow_in = 1; e.zhigh_in = 1; e.op_code = opc; ex.push_back(e);
                e = act_e(); e.zlow_out = 1; e.lo_in = 1; ex.push_back(e);
                e = act_e(); e.zhigh_out = 1; e.hi_in = 1; ex.push_back(e);
            end
            2: begin
                e = act_e(); e.r_out = bsel(rb); e.zlow_in = 1; e.zhigh_in = 1; e.op_code = opc; ex.push_back(e);
                e = act_e(); e.zlow_out = 1; e.r_in = bsel(ra); ex.push_back(e);
            end
            default: ex.push_back(act_e());
        endcase

        last = ex.size() - 1;
        for (int i = 0; i <= last; i++) begin
            if (abort_t4 && i == 1) begin
                do_reset(2);
                return;
            end
            r = 1'($urandom);
`ifndef SINGLE_STEP_EN
            if (i == last) r = final_run;
`endif
            drive(1'b1, r, 1'($urandom), instr, ex[i]);
            if (i == 0 && cls == 5) ill = 1'b1;
        end

        if (cls == 4) begin
            for (int k = 0; k < 6; k++) begin
                e = '0; e.halted = 1;
                drive(1'b1, 1'($urandom), 1'($urandom), $urandom, e);
            end
            return;
        end

`ifdef SINGLE_STEP_EN
        repeat ($urandom_range(0, 2)) drive(1'b1, 1'($urandom), 1'($urandom), instr, act_e());
        drive_s(final_run, 1'($urandom), instr, 1'b1, act_e());
`endif
        at_idle = !final_run;
    endtask

    initial begin
        logic [4:0] opc;
        do_reset(3);

        run_instr(32'h1A2B_8000, 0, 1'b1, 1'b0);
        run_instr(32'h1A2B_8000, 3, 1'b1, 1'b0);
        run_instr(32'h7898_0000, 1, 1'b0, 1'b0);
        run_instr({5'b11111, 27'h0}, 0, 1'b1, 1'b0);
        run_instr(32'h1A2B_8000, 0, 1'b1, 1'b1);

        for (int n = 0; n < 40; n++) begin
            opc = 5'($urandom);
            if (opc == 5'd27) opc = 5'd26;
            run_instr({opc, 27'($urandom)}, int'($urandom_range(0, 3)), ($urandom % 4) != 0, 1'b0);
        end

        run_instr({5'd27, 27'($urandom)}, 0, 1'b1, 1'b0);
        do_reset(2);
        run_instr({5'd16, 27'($urandom)}, 2, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hardwired control unit placed directly upstream of the Datapath. It drives every Datapath enable: register in/out strobes, PC/MAR/MDR/IR/Y/Z/HI/LO controls, `read` and the 5-bit ALU `op_code`. It runs the fetch (T0–T2) and execute (T3–T6) sequence, decoding the IR value the Datapath returns. This replaces the hand-sequenced stimulus used in Phase 1 bring-up.

Parameters:
- NREG, 16, number of general registers; sets the width of the one-hot `r_in`/`r_out` buses.
- OPW, 5, width of the opcode field and of `op_code`.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 permits instruction fetch.
- mem_ready  in  1  memory data valid during T1.
- ir  in  32  IR contents from Datapath. Fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
- pc_out, pc_increment, MARin, pc_in, read, mdr_in, mdr_out, ir_in, y_in  out  1 each  Datapath strobes.
- zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in  out  1 each  Datapath strobes.
- r_in  out  NREG  one-hot register load.
- r_out  out  NREG  one-hot register drive.
- op_code  out  OPW  ALU operation.
- busy  out  1  high in any state other than IDLE/HALTED.
- halted  out  1  high in HALTED.
- illegal  out  1  sticky; set on an undefined opcode.

Behaviour:
- Moore FSM. Outputs are decoded combinationally from the registered state and `ir`. Each output is held for the whole cycle; the Datapath samples it at the next rising edge.
- Reset (clr=0, any time, including mid-instruction): state goes to IDLE immediately; every output is 0, including `op_code`=0; `illegal` is cleared.
- States and actions:
  - IDLE: all strobes 0. Go to T0 when run=1.
  - T0: pc_out, pc_increment, MARin, zlow_in, zhigh_in.
  - T1: zlow_out, pc_in, read, mdr_in. Stay in T1 while mem_ready=0. Strobes stay asserted throughout the wait; pc_in is asserted only on the cycle mem_ready=1. Advance to T2 on the edge where mem_ready=1.
  - T2: mdr_out, ir_in. Next state T3; ir is valid from T3 onward.
- Operation classes by opcode:
  - ALU3, opcodes 00000–01010:
    - T3: r_out[Rb], y_in.
    - T4: r_out[Rc], zlow_in, zhigh_in, op_code=opcode.
    - T5: zlow_out, r_in[Ra]. Then END.
  - MULDIV, opcodes 01111 (mul) and 10000 (div):
    - T3: r_out[Ra], y_in.
    - T4: r_out[Rb], zlow_in, zhigh_in, op_code=opcode.
    - T5: zlow_out, lo_in.
    - T6: zhigh_out, hi_in. Then END.
  - UNARY, opcodes 10001 (neg) and 10010 (not):
    - T3: r_out[Rb], zlow_in, zhigh_in, op_code=opcode.
    - T4: zlow_out, r_in[Ra]. Then END.
  - NOP, 11010: END directly from T3; no strobes asserted in T3.
  - HALT, 11011: HALTED from T3. HALTED is exited only by reset.
  - Any other opcode: set `illegal`; treat as NOP.
- END (pseudo-transition evaluated at the last execute cycle): next state is T0 if run=1, else IDLE.
- If run falls mid-instruction, the current instruction completes.
- `op_code` is 0 in every state except the ALU cycle listed above.
- `r_in` and `r_out` are never both nonzero in the same cycle, and each has at most one bit set.
- Register index ≥ NREG drives no bit.
- R0 is not special-cased.

Optional Feature:
- Macro SINGLE_STEP_EN.
- When defined:
  - Add input `step` (1 bit).
  - END goes to STEP_WAIT (all strobes 0, busy=1) instead of T0/IDLE.
  - STEP_WAIT leaves on the first cycle with step=1: to T0 if run=1, else IDLE.
  - A step=1 already high at entry is ignored until it has been seen low once.
- When undefined: no `step` port, no STEP_WAIT state; END behaves as above.

Test Plan:
- Reset mid-T4 → outputs all 0 on the same cycle as clr falls. After clr rises with run=0, FSM stays IDLE and busy=0.
- run=1, mem_ready=1, ir=0x1A2B8000 (opcode 00011, Ra=4, Rb=5, Rc=7) → sequence T0..T5 in 6 cycles:
  - T3: r_out=0x0020, y_in=1.
  - T4: r_out=0x0080, op_code=00011, zlow_in=1.
  - T5: zlow_out=1, r_in=0x0010.
- mem_ready held 0 for 3 cycles in T1 → read=1 and mdr_in=1 for 4 cycles; pc_in=1 only on the 4th; T2 follows.
- ir=0x78980000 (mul, Ra=1, Rb=3) → T5: lo_in=1, zlow_out=1; T6: hi_in=1, zhigh_out=1; 7 cycles total.
- ir opcode 11011 → halted=1, busy=0; run toggling causes no further strobes. Opcode 11111 → illegal=1, NOP timing.
- SINGLE_STEP_EN: after an ALU3 instruction the FSM holds in STEP_WAIT; a 1-cycle step pulse → T0 on the next cycle.
